load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_align.sv | 44 ++++
 rtl/load_store_unit.sv | 161 ++++++++++++++++
 tb/tb_load_store_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the request legality check applied at accept time.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // Flags an illegal width code, a misaligned halfword/word or an out-of-range address
  function automatic logic req_illegal(input logic        write,
                                       input logic [2:0]  funct3,
                                       input logic [31:0] addr,
                                       input logic [31:0] limit);
    logic bad_code;
    logic misaligned;
    if (write) begin
      bad_code = (funct3 >= 3'd3);
    end else begin
      bad_code = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    end
    case (funct3[1:0])
      2'd1:    misaligned = addr[0];
      2'd2:    misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    return bad_code || misaligned || (addr >= limit);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends a load from a memory word, and
// merges store data into the addressed byte/halfword lane of a word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = word[{lane, 3'b000} +: 8];
  assign half_s = word[{lane[1], 4'b0000} +: 16];

  // Load lane select with sign or zero extension
  always_comb begin
    load_data = 32'h0000_0000;
    case (funct3)
      F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
      F3_H:    load_data = {{16{half_s[15]}}, half_s};
      F3_W:    load_data = word;
      F3_BU:   load_data = {24'h00_0000, byte_s};
      F3_HU:   load_data = {16'h0000, half_s};
      default: load_data = 32'h0000_0000;
    endcase
  end

  // Store merge: only the addressed lane of the read word is replaced
  always_comb begin
    store_word = word;
    case (funct3)
      F3_B:    store_word[{lane, 3'b000} +: 8]     = wdata[7:0];
      F3_H:    store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      F3_W:    store_word = wdata;
      default: store_word = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time through IDLE/RD/WR/RESP, with
// read-modify-write for sub-word stores on a word-wide memory port.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);

  lsu_state_e  state_r;
  logic        write_r;
  logic [2:0]  funct3_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] rd_word_r;
  logic        resp_valid_r;
  logic        resp_err_r;
  logic [31:0] resp_rdata_r;

  logic        accept_s;
  logic        illegal_s;
  logic [31:0] align_word_s;
  logic [31:0] load_data_s;
  logic [31:0] store_word_s;

  assign req_ready = (state_r == IDLE) && !rst;
  assign accept_s  = req_valid && req_ready;
  assign illegal_s = req_illegal(req_write, req_funct3, req_addr, 32'(ADDR_LIMIT));

  // Loads extract straight from the live read data; the RMW merge uses the captured word
  assign align_word_s = (state_r == RD) ? mem_read_data : rd_word_r;

  lsu_align u_align (
    .word       (align_word_s),
    .lane       (addr_r[1:0]),
    .funct3     (funct3_r),
    .wdata      (wdata_r),
    .load_data  (load_data_s),
    .store_word (store_word_s)
  );

  assign resp_valid = resp_valid_r && !rst;
  assign resp_err   = resp_err_r && !rst;
  assign resp_rdata = rst ? 32'h0000_0000 : resp_rdata_r;

  // Memory port decode; everything is forced low under reset so no write lands on a reset edge
  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = 32'h0000_0000;
    mem_write_data = 32'h0000_0000;
    if (!rst) begin
      case (state_r)
        RD: begin
          mem_read = 1'b1;
          mem_addr = {addr_r[31:2], 2'b00};
        end
        WR: begin
          mem_write      = 1'b1;
          mem_addr       = {addr_r[31:2], 2'b00};
          mem_write_data = store_word_s;
        end
        default: begin
          mem_read       = 1'b0;
          mem_write      = 1'b0;
          mem_addr       = 32'h0000_0000;
          mem_write_data = 32'h0000_0000;
        end
      endcase
    end else begin
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_addr       = 32'h0000_0000;
      mem_write_data = 32'h0000_0000;
    end
  end

  // Request latch, state sequencing and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      write_r      <= 1'b0;
      funct3_r     <= 3'd0;
      addr_r       <= 32'h0000_0000;
      wdata_r      <= 32'h0000_0000;
      rd_word_r    <= 32'h0000_0000;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            write_r  <= req_write;
            funct3_r <= req_funct3;
            addr_r   <= req_addr;
            wdata_r  <= req_wdata;
            if (illegal_s) begin
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_rdata_r <= 32'h0000_0000;
            end else if (req_write && (req_funct3 == F3_W)) begin
              state_r <= WR;
            end else begin
              state_r <= RD;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RD: begin
          rd_word_r <= mem_read_data;
          if (write_r) begin
            state_r <= WR;
          end else begin
            state_r      <= RESP;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= load_data_s;
          end
        end
        WR: begin
          state_r      <= RESP;
          resp_valid_r <= 1'b1;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= 32'h0000_0000;
        end
        RESP: begin
          state_r      <= IDLE;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= 32'h0000_0000;
        end
        default: begin
          state_r      <= IDLE;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= 32'h0000_0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, a reset-abort
// sequence, and a randomized run against a transaction-level reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  logic        fill_en;
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_val;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  load_store_unit #(.ADDR_LIMIT(1024)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  assign mem_read_data = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end
    if (pl_en) mem[pl_idx] <= pl_val;
    if (mem_write) mem[mem_addr[9:2]] <= mem_write_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h want %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_val = val;
    ref_mem[idx] = val;
    tick();
    pl_en  = 1'b0;
  endtask

  // Transaction-level reference: outcome, latency and memory effect of one request
  task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic err, output logic [31:0] rdata,
                       output int lat, output logic rd, output logic wt,
                       output logic [31:0] nword);
    int size;
    int sh;
    logic legal;
    logic [31:0] word;
    logic [31:0] mask;
    logic [31:0] raw;
    case (f3[1:0])
      2'd0:    size = 1;
      2'd1:    size = 2;
      2'd2:    size = 4;
      default: size = 0;
    endcase
    legal = wr ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    err = !legal || (a >= 32'd1024);
    if (size != 0) begin
      if ((a % 32'(size)) != 32'd0) err = 1'b1;
    end
    rdata = 32'd0; lat = 1; rd = 1'b0; wt = 1'b0; nword = 32'd0;
    if (!err) begin
      word = ref_mem[a[9:2]];
      sh   = int'(a[1:0]) * 8;
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      if (!wr) begin
        raw = (word >> sh) & mask;
        if (!f3[2] && size < 4 && raw[8 * size - 1]) raw = raw | ~mask;
        rdata = raw;
        lat = 2;
        rd = 1'b1;
      end else begin
        nword = (word & ~(mask << sh)) | ((wd & mask) << sh);
        ref_mem[a[9:2]] = nword;
        wt  = 1'b1;
        rd  = (size != 4);
        lat = rd ? 3 : 2;
      end
    end
  endtask

  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rdata, output logic err,
                        output int lat, output logic srd, output logic swr);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    chk("ready_before_accept", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0; req_funct3 = 3'd7;
    lat = 99; rdata = 32'd0; err = 1'b0; srd = 1'b0; swr = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (mem_read) srd = 1'b1;
      if (mem_write) swr = 1'b1;
      if (resp_valid) begin
        lat = i; rdata = resp_rdata; err = resp_err;
        break;
      end
      tick();
    end
    tick();
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pre;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic        exp_rd;
    logic        exp_wr;
    logic [31:0] exp_word;
  } vec_t;

  vec_t tbl [18];

  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] g_rdata;
    logic        g_err, g_rd, g_wr;
    int          g_lat;
    logic        have, t_err, t_rd, t_wt;
    logic [31:0] t_rdata, t_word, t_waddr;
    int          t_acc, t_lat, d, pick;
    logic        e_ready, e_resp, e_mr, e_mw;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; fill_en = 1'b1; pl_en = 1'b0;
    pl_idx = 8'd0; pl_val = 32'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    tick();
    fill_en = 1'b0;
    tick();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

    // Directed vectors
    tbl[0]  = '{1'b0, 3'd2, 32'h010, 32'h0,    32'h8081F2F3, 32'h8081F2F3, 1'b0, 2, 1'b1, 1'b0, 32'h8081F2F3};
    tbl[1]  = '{1'b0, 3'd0, 32'h013, 32'h0,    32'h8081F2F3, 32'hFFFFFF80, 1'b0, 2, 1'b1, 1'b0, 32'h8081F2F3};
    tbl[2]  = '{1'b0, 3'd4, 32'h013, 32'h0,    32'h8081F2F3, 32'h00000080, 1'b0, 2, 1'b1, 1'b0, 32'h8081F2F3};
    tbl[3]  = '{1'b0, 3'd1, 32'h012, 32'h0,    32'h8081F2F3, 32'hFFFF8081, 1'b0, 2, 1'b1, 1'b0, 32'h8081F2F3};
    tbl[4]  = '{1'b0, 3'd5, 32'h010, 32'h0,    32'h8081F2F3, 32'h0000F2F3, 1'b0, 2, 1'b1, 1'b0, 32'h8081F2F3};
    tbl[5]  = '{1'b0, 3'd0, 32'h011, 32'h0,    32'h8081F2F3, 32'hFFFFFFF2, 1'b0, 2, 1'b1, 1'b0, 32'h8081F2F3};
    tbl[6]  = '{1'b1, 3'd0, 32'h021, 32'hAB,   32'h11223344, 32'h0,        1'b0, 3, 1'b1, 1'b1, 32'h1122AB44};
    tbl[7]  = '{1'b1, 3'd1, 32'h022, 32'hBEEF, 32'h11223344, 32'h0,        1'b0, 3, 1'b1, 1'b1, 32'hBEEF3344};
    tbl[8]  = '{1'b1, 3'd2, 32'h024, 32'hDEADBEEF, 32'h0,    32'h0,        1'b0, 2, 1'b0, 1'b1, 32'hDEADBEEF};
    tbl[9]  = '{1'b1, 3'd1, 32'h003, 32'h1234, 32'hCAFEF00D, 32'h0,        1'b1, 1, 1'b0, 1'b0, 32'hCAFEF00D};
    tbl[10] = '{1'b0, 3'd2, 32'h006, 32'h0,    32'h0BADF00D, 32'h0,        1'b1, 1, 1'b0, 1'b0, 32'h0BADF00D};
    tbl[11] = '{1'b0, 3'd3, 32'h010, 32'h0,    32'h8081F2F3, 32'h0,        1'b1, 1, 1'b0, 1'b0, 32'h8081F2F3};
    tbl[12] = '{1'b0, 3'd2, 32'h400, 32'h0,    32'h0,        32'h0,        1'b1, 1, 1'b0, 1'b0, 32'h0};
    tbl[13] = '{1'b1, 3'd3, 32'h030, 32'h55,   32'h01020304, 32'h0,        1'b1, 1, 1'b0, 1'b0, 32'h01020304};
    tbl[14] = '{1'b0, 3'd2, 32'h3FC, 32'h0,    32'h12345678, 32'h12345678, 1'b0, 2, 1'b1, 1'b0, 32'h12345678};
    tbl[15] = '{1'b0, 3'd6, 32'h040, 32'h0,    32'h0,        32'h0,        1'b1, 1, 1'b0, 1'b0, 32'h0};
    tbl[16] = '{1'b1, 3'd0, 32'h3FF, 32'h5A,   32'hAABBCCDD, 32'h0,        1'b0, 3, 1'b1, 1'b1, 32'h5ABBCCDD};
    tbl[17] = '{1'b0, 3'd1, 32'h3FE, 32'h0,    32'h80FF0000, 32'hFFFF80FF, 1'b0, 2, 1'b1, 1'b0, 32'h80FF0000};

    for (int v = 0; v < 18; v++) begin
      if (tbl[v].addr < 32'd1024) preload(tbl[v].addr[9:2], tbl[v].pre);
      do_req(tbl[v].wr, tbl[v].f3, tbl[v].addr, tbl[v].wdata, g_rdata, g_err, g_lat, g_rd, g_wr);
      chk($sformatf("vec%0d_rdata", v), g_rdata, tbl[v].exp_rdata);
      chk($sformatf("vec%0d_err", v), {31'd0, g_err}, {31'd0, tbl[v].exp_err});
      chk($sformatf("vec%0d_latency", v), 32'(g_lat), 32'(tbl[v].exp_lat));
      chk($sformatf("vec%0d_mem_read_seen", v), {31'd0, g_rd}, {31'd0, tbl[v].exp_rd});
      chk($sformatf("vec%0d_mem_write_seen", v), {31'd0, g_wr}, {31'd0, tbl[v].exp_wr});
      if (tbl[v].addr < 32'd1024) begin
        chk($sformatf("vec%0d_mem_word", v), mem[tbl[v].addr[9:2]], tbl[v].exp_word);
        ref_mem[tbl[v].addr[9:2]] = tbl[v].exp_word;
      end
    end

    // Reset landing on the WR cycle of a halfword RMW
    preload(8'd16, 32'h55667788);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd1;
    req_addr = 32'h42; req_wdata = 32'h0000_1234;
    tick();
    req_valid = 1'b0;
    chk("abort_rd_phase", {31'd0, mem_read}, 32'd1);
    tick();
    chk("abort_wr_phase", {31'd0, mem_write}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_write_gated", {31'd0, mem_write}, 32'd0);
    tick();
    chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    chk("abort_ready_in_rst", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_ready_after", {31'd0, req_ready}, 32'd1);
    chk("abort_mem_unchanged", mem[16], 32'h55667788);
    tick();
    chk("abort_no_late_resp", {31'd0, resp_valid}, 32'd0);

    // Randomized run; the second half keeps req_valid high every cycle
    have = 1'b0; t_acc = 0; t_lat = 0; t_err = 1'b0; t_rd = 1'b0; t_wt = 1'b0;
    t_rdata = 32'd0; t_word = 32'd0; t_waddr = 32'd0;
    for (int k = 0; k < 400; k++) begin
      d       = cyc - t_acc;
      e_ready = !have || (d > t_lat);
      e_resp  = have && (d == t_lat);
      e_mr    = have && t_rd && (d == 1);
      e_mw    = have && t_wt && (d == (t_rd ? 2 : 1));
      chk("rnd_req_ready", {31'd0, req_ready}, {31'd0, e_ready});
      chk("rnd_resp_valid", {31'd0, resp_valid}, {31'd0, e_resp});
      chk("rnd_mem_read", {31'd0, mem_read}, {31'd0, e_mr});
      chk("rnd_mem_write", {31'd0, mem_write}, {31'd0, e_mw});
      chk("rnd_mem_addr", mem_addr, (e_mr || e_mw) ? t_waddr : 32'd0);
      chk("rnd_mem_wdata", mem_write_data, e_mw ? t_word : 32'd0);
      if (e_resp) begin
        chk("rnd_rdata", resp_rdata, t_rdata);
        chk("rnd_err", {31'd0, resp_err}, {31'd0, t_err});
        if (t_wt) chk("rnd_mem_word", mem[t_waddr[9:2]], t_word);
      end
      req_valid  = (k >= 200) ? 1'b1 : ($urandom_range(0, 3) != 0);
      req_write  = 1'($urandom_range(0, 1));
      req_funct3 = 3'($urandom_range(0, 7));
      req_wdata  = $urandom;
      pick = int'($urandom_range(0, 9));
      if (pick < 7)      req_addr = $urandom_range(0, 127);
      else if (pick < 9) req_addr = 32'd1016 + $urandom_range(0, 15);
      else               req_addr = $urandom;
      if (req_valid && e_ready) begin
        model(req_write, req_funct3, req_addr, req_wdata, t_err, t_rdata, t_lat, t_rd, t_wt, t_word);
        have    = 1'b1;
        t_acc   = cyc;
        t_waddr = {req_addr[31:2], 2'b00};
      end
      tick();
    end
    req_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
